float_add_arbiter: RTL and testbench
====================================

# float_add_arbiter

Shares one combinational `float_add` datapath (8-bit unsigned float: exponent [7:5], mantissa [4:0]) between two requesters. A round-robin (or fixed-priority) arbiter grants one addition per cycle. Operands go into an operand register, and the sum goes into a result register. Each requester gets a one-cycle completion pulse, so the adder runs fully pipelined with throughput of one add per clock.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate on contention; 0 = fixed priority, port 0 always wins.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: port 0 request; held with stable operands until granted.
- `a0` in 8: port 0 operand A.
- `b0` in 8: port 0 operand B.
- `gnt0` out 1: port 0 grant, combinational, same cycle as the accepted `req0`.
- `done0` out 1: one-cycle pulse; `result` is valid for port 0.
- `req1`, `a1`, `b1`, `gnt1`, `done1`: identical for port 1.
- `result` out 8: registered sum; holds its last value between `done` pulses.

## Operation
- Arbitration each cycle:
  - Neither request: no grant.
  - One request: that port is granted.
  - Both requests, `ROUND_ROBIN=1`: grant the port not in `last_gnt`.
  - Both requests, `ROUND_ROBIN=0`: grant port 0.
  - `gnt0` and `gnt1` are mutually exclusive.
- `last_gnt` updates on every grant. It resets to 1, so port 0 wins the first contended cycle.
- On a grant edge, the granted operands load into `op_a`/`op_b`; `s1_vld` is set to 1 and `s1_id` to the granted port. With no grant, `s1_vld` is 0.
- Stage 2: `result` ← `float_add(op_a, op_b)`, gated by `s1_vld`; `s2_vld` ← `s1_vld`; `s2_id` ← `s1_id`.
- `done_i` = `s2_vld & (s2_id == i)`. `result` is not updated when `s1_vld` is 0.
- Arithmetic comes entirely from `float_add`:
  - Operand order is normalized internally (larger exponent first).
  - The smaller operand's mantissa is right-shifted by the exponent difference (truncating).
  - Mantissa carry increments the exponent, giving mantissa {1, sum[4:1]}.
  - Exponent 111 with a carry saturates to 0xFF.
- A requester must not change operands while `req` is high and `gnt` is low. Dropping `req` before a grant withdraws the request with no side effects.

## Timing
- Reset values: `gnt0`/`gnt1` = 0 (no request during reset), `done0`/`done1` = 0, `result` = 0x00, `s1_vld`/`s2_vld` = 0, `last_gnt` = 1.
- Latency: a grant in cycle N produces `done_i` and a valid `result` in cycle N+2.
- Back-to-back: grants in N and N+1 produce `done` in N+2 and N+3. No bubbles, no stalls, no backpressure on outputs.
- A requester may re-request in the cycle after its grant. Under continuous contention with `ROUND_ROBIN=1`, grants alternate 0,1,0,1.
- Reset asserted mid-operation clears both pipeline valids immediately. In-flight results are discarded: no `done`, `result` = 0x00.
- The first arbitration happens in the first cycle after reset deasserts.

## Structure
- Shared package holds:
  - Format constants: `EXP_W=3`, `MAN_W=5`, `FLOAT_W=8`, `FLOAT_MAX=8'hFF`.
  - Port ID constants: `PORT0=0`, `PORT1=1`.
- One sub-module: an instance of the existing `float_add`, placed between `op_a`/`op_b` and `result`. The arbiter, pointer, and pipeline registers stay in this module.

## Test plan
- Single request: `req0`, a0=0x22, b0=0x21 → `gnt0` that cycle; `done0` 2 cycles later with `result`=0x23; `done1` never asserts.
- Mantissa carry: `req1`, a1=0x30, b1=0x30 → `result`=0x50 with `done1`.
- Exponent alignment and swap: a0=0x28, b0=0x48 → `result`=0x4C.
- Saturation: a0=0xFF, b0=0xE1 → `result`=0xFF.
- Contention with `ROUND_ROBIN=1`:
  - Stimulus: `req0` and `req1` held for 4 cycles right after reset, with port 0 ops (0x22,0x21) and port 1 ops (0x30,0x30).
  - Grants: 0,1,0,1.
  - Completions: `done0`/0x23, `done1`/0x50, alternating in cycles 3–6.
  - Repeat with `ROUND_ROBIN=0` → port 0 wins every cycle and `done1` never asserts.
- Reset mid-flight: `rst` pulsed one cycle after `gnt0` → no `done0`, `result`=0x00; the next request completes normally.

Source files
------------

// File: rtl/float_add_arbiter_pkg.sv
// Shared constants and types for the two-port float adder arbiter.
// Format: 8-bit unsigned float, exponent [7:5], mantissa [4:0].
package float_add_arbiter_pkg;

    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MAN_W   = 5;
    localparam int unsigned FLOAT_W = EXP_W + MAN_W;

    localparam logic [FLOAT_W-1:0] FLOAT_MAX = 8'hFF;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef logic [FLOAT_W-1:0] float_t;

    typedef struct packed {
        float_t a;
        float_t b;
    } operands_t;

endpackage

// File: rtl/float_add_arbiter_if.sv
// Requester-side bus of the arbiter: two request/operand ports plus shared result.
interface float_add_arbiter_if;
    import float_add_arbiter_pkg::*;

    logic   req0;
    float_t a0;
    float_t b0;
    logic   gnt0;
    logic   done0;

    logic   req1;
    float_t a1;
    float_t b1;
    logic   gnt1;
    logic   done1;

    float_t result;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, done0, gnt1, done1, result
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, done0, gnt1, done1, result
    );

endinterface

// File: rtl/float_add_arbiter_float_add.sv
// Combinational add of two 8-bit unsigned floats (truncating alignment,
// carry renormalises, exponent overflow saturates to FLOAT_MAX).
module float_add
    import float_add_arbiter_pkg::*;
(
    input  float_t a,
    input  float_t b,
    output float_t sum
);

    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] exp_big;
    logic [EXP_W-1:0] exp_diff;
    logic [MAN_W-1:0] man_big;
    logic [MAN_W-1:0] man_small;
    logic [MAN_W-1:0] man_aligned;
    logic [MAN_W:0]   man_sum;

    always_comb begin
        exp_a = a[FLOAT_W-1:MAN_W];
        exp_b = b[FLOAT_W-1:MAN_W];

        // Larger exponent leads; the other mantissa is aligned to it.
        if (exp_b > exp_a) begin
            exp_big   = exp_b;
            exp_diff  = exp_b - exp_a;
            man_big   = b[MAN_W-1:0];
            man_small = a[MAN_W-1:0];
        end else begin
            exp_big   = exp_a;
            exp_diff  = exp_a - exp_b;
            man_big   = a[MAN_W-1:0];
            man_small = b[MAN_W-1:0];
        end

        man_aligned = man_small >> exp_diff;
        man_sum     = {1'b0, man_big} + {1'b0, man_aligned};

        if (man_sum[MAN_W]) begin
            if (exp_big == {EXP_W{1'b1}}) begin
                sum = FLOAT_MAX;
            end else begin
                sum = {exp_big + EXP_W'(1), 1'b1, man_sum[MAN_W-1:1]};
            end
        end else begin
            sum = {exp_big, man_sum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/float_add_arbiter.sv
// Two-requester arbiter sharing one float_add; operand and result registers
// give a fully pipelined adder with done two cycles after the grant.
module float_add_arbiter
    import float_add_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    float_add_arbiter_if.slave   bus
);

    logic      gnt0;
    logic      gnt1;
    logic      prefer1;
    logic      last_gnt;
    operands_t op;
    logic      s1_vld;
    logic      s1_id;
    logic      s2_vld;
    logic      s2_id;
    float_t    sum;
    float_t    result;

    // Port 1 only wins contention under round-robin when port 0 went last.
    always_comb begin
        prefer1 = 1'b0;
        if (ROUND_ROBIN) begin
            prefer1 = (last_gnt == PORT0);
        end
        gnt0 = ~rst & bus.req0 & ~(bus.req1 & prefer1);
        gnt1 = ~rst & bus.req1 & ~gnt0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORT1;
            op       <= '0;
            s1_vld   <= 1'b0;
            s1_id    <= PORT0;
            s2_vld   <= 1'b0;
            s2_id    <= PORT0;
            result   <= '0;
        end else begin
            s1_vld <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                last_gnt <= gnt1 ? PORT1 : PORT0;
                s1_id    <= gnt1 ? PORT1 : PORT0;
                op.a     <= gnt1 ? bus.a1 : bus.a0;
                op.b     <= gnt1 ? bus.b1 : bus.b0;
            end
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
            if (s1_vld) begin
                result <= sum;
            end
        end
    end

    float_add u_float_add (
        .a   (op.a),
        .b   (op.b),
        .sum (sum)
    );

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    assign bus.done0  = s2_vld & (s2_id == PORT0);
    assign bus.done1  = s2_vld & (s2_id == PORT1);
    assign bus.result = result;

endmodule

// File: tb/tb_float_add_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances, directed vectors.
module tb_float_add_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q_rr[$];
    exp_t q_fp[$];

    always #5 clk = ~clk;

    float_add_arbiter_if bus_rr();
    float_add_arbiter_if bus_fp();

    float_add_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr.slave)
    );

    float_add_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp.slave)
    );

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Pop and compare whenever either DUT reports a completion.
    task automatic mon(input bit fp, input logic d0, input logic d1, input logic [7:0] r);
        exp_t e;
        if (d0 | d1) begin
            chk(fp ? "fp_done_excl" : "rr_done_excl", 8'(d0 & d1), 8'h00);
            if ((fp ? q_fp.size() : q_rr.size()) == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: got done0=%0b done1=%0b result=0x%02h expected no done at %0t",
                         fp ? "fp_unexpected_done" : "rr_unexpected_done", d0, d1, r, $time);
            end else begin
                e = fp ? q_fp.pop_front() : q_rr.pop_front();
                chk(fp ? "fp_done_port" : "rr_done_port", 8'(d1), 8'(e.id));
                chk(fp ? "fp_result" : "rr_result", r, e.res);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(1'b0, bus_rr.done0, bus_rr.done1, bus_rr.result);
            mon(1'b1, bus_fp.done0, bus_fp.done1, bus_fp.result);
        end
    end

    task automatic set_idle();
        bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
        bus_rr.a0 = '0; bus_rr.b0 = '0; bus_rr.a1 = '0; bus_rr.b1 = '0;
        bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0;
        bus_fp.a0 = '0; bus_fp.b0 = '0; bus_fp.a1 = '0; bus_fp.b1 = '0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus on the selected DUT; checks grants, queues the expected sum.
    task automatic drive(input bit fp,
                         input bit r0, input logic [7:0] x0, input logic [7:0] y0,
                         input bit r1, input logic [7:0] x1, input logic [7:0] y1,
                         input bit eg0, input bit eg1, input logic [7:0] er, input bit push);
        logic g0, g1;
        set_idle();
        if (fp) begin
            bus_fp.req0 = r0; bus_fp.a0 = x0; bus_fp.b0 = y0;
            bus_fp.req1 = r1; bus_fp.a1 = x1; bus_fp.b1 = y1;
        end else begin
            bus_rr.req0 = r0; bus_rr.a0 = x0; bus_rr.b0 = y0;
            bus_rr.req1 = r1; bus_rr.a1 = x1; bus_rr.b1 = y1;
        end
        @(negedge clk);
        g0 = fp ? bus_fp.gnt0 : bus_rr.gnt0;
        g1 = fp ? bus_fp.gnt1 : bus_rr.gnt1;
        chk(fp ? "fp_gnt0" : "rr_gnt0", 8'(g0), 8'(eg0));
        chk(fp ? "fp_gnt1" : "rr_gnt1", 8'(g1), 8'(eg1));
        if (push && (eg0 | eg1)) begin
            if (fp) q_fp.push_back('{id: eg1, res: er});
            else    q_rr.push_back('{id: eg1, res: er});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rr_result", bus_rr.result, 8'h00);
        chk("rst_fp_result", bus_fp.result, 8'h00);
        chk("rst_rr_done", 8'({bus_rr.done1, bus_rr.done0}), 8'h00);
        chk("rst_rr_gnt", 8'({bus_rr.gnt1, bus_rr.gnt0}), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requests on the round-robin instance.
        drive(1'b0, 1'b1, 8'h22, 8'h21, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h23, 1'b1);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 8'h30, 1'b0, 1'b1, 8'h50, 1'b1);
        drive(1'b0, 1'b1, 8'h28, 8'h48, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h4C, 1'b1);
        drive(1'b0, 1'b1, 8'hFF, 8'hE1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hE1, 8'hE2, 1'b0, 1'b1, 8'hE3, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h1F, 8'hE0, 1'b0, 1'b1, 8'hE0, 1'b1);
        idle(4);

        // Contention right after reset: round-robin alternates starting with port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h22, 8'h21, 1'b1, 8'h30, 8'h30,
                  (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 8'h23 : 8'h50, 1'b1);
        end
        idle(4);

        // Fixed priority: port 0 wins every contended cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h22, 8'h21, 1'b1, 8'h30, 8'h30, 1'b1, 1'b0, 8'h23, 1'b1);
        end
        idle(4);

        // Reset one cycle after a grant discards the in-flight add.
        drive(1'b0, 1'b1, 8'h22, 8'h21, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h23, 1'b0);
        set_idle();
        rst = 1'b1;
        #1;
        chk("midrst_result", bus_rr.result, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        chk("midrst_result_hold", bus_rr.result, 8'h00);
        drive(1'b0, 1'b1, 8'h28, 8'h48, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h4C, 1'b1);
        idle(4);

        chk("rr_queue_empty", 8'(q_rr.size()), 8'h00);
        chk("fp_queue_empty", 8'(q_fp.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
